cic_interp_var: RTL and testbench

- Variable-rate CIC interpolator for the transmit (DUC) path; the counterpart of the receive-side variable CIC decimator.
- Accepts low-rate baseband samples through a one-entry valid/ready buffer and runs STAGES combs at the input rate.
- Zero-stuffs by R and runs STAGES integrators at the high rate, paced by ce_out.
- Emits gain-normalised, rounded samples toward the DAC/upconverter.

---
 rtl/cic_interp_var.sv | 183 ++++++++++++++++++
 tb/tb_cic_interp_var.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cic_interp_var.sv
// Variable-rate CIC interpolator: combs at the input rate, integrators paced by ce_out.
// Define CIC_INTERP_SAT_EN to clamp rounding overflow and add a sticky sat_flag output.
module cic_interp_var #(
  parameter int STAGES    = 3,
  parameter int IN_WIDTH  = 18,
  parameter int OUT_WIDTH = 18,
  parameter int ACC_WIDTH = 32
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [7:0]                  rate,
  input  logic                        ce_out,
  input  logic signed [IN_WIDTH-1:0]  in_data,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic                        in_req,
  output logic signed [OUT_WIDTH-1:0] out_data,
  output logic                        out_valid,
  output logic                        underrun,
  input  logic                        underrun_clr,
`ifdef CIC_INTERP_SAT_EN
  output logic                        sat_flag,
`endif
  output logic                        rate_err
);

  // Smallest g with 2^g >= r^(STAGES-1), i.e. ceil((STAGES-1)*log2 r).
  function automatic int gain_bits(input int r);
    longint p;
    int g;
    p = 1;
    for (int i = 1; i < STAGES; i++) p = p * longint'(r);
    g = 0;
    for (int i = 0; i < 63; i++) if ((longint'(1) << g) < p) g = g + 1;
    return g;
  endfunction

  function automatic logic rate_supported(input logic [7:0] r);
    case (r)
      8'd2, 8'd4, 8'd5, 8'd8, 8'd10, 8'd20, 8'd40: rate_supported = 1'b1;
      default: rate_supported = 1'b0;
    endcase
  endfunction

  localparam int G_R2  = gain_bits(2);
  localparam int G_R4  = gain_bits(4);
  localparam int G_R5  = gain_bits(5);
  localparam int G_R8  = gain_bits(8);
  localparam int G_R10 = gain_bits(10);
  localparam int G_R20 = gain_bits(20);
  localparam int G_R40 = gain_bits(40);

  logic [7:0]                  rate_q;
  logic [7:0]                  phase;
  logic signed [IN_WIDTH-1:0]  buf_data;
  logic                        buf_full;
  logic signed [ACC_WIDTH-1:0] comb_prev [STAGES];
  logic signed [ACC_WIDTH-1:0] comb_out  [STAGES];
  logic signed [ACC_WIDTH-1:0] integ     [STAGES];
  logic signed [ACC_WIDTH-1:0] comb_in;
  logic signed [ACC_WIDTH-1:0] integ_in;
  logic                        ce_d;
  logic                        rate_change;
  logic                        wrap;
  logic                        accept;
  int                          gain;
  int                          lsb_m1;
  logic [OUT_WIDTH:0]          acc_sh;
  logic [OUT_WIDTH-1:0]        trunc;
  logic                        round_bit;
  logic [OUT_WIDTH-1:0]        rounded;

  assign rate_change = (rate != rate_q);
  assign wrap        = ce_out && !rate_err && !rate_change && (phase == rate_q - 8'd1);
  assign in_req      = wrap;
  assign in_ready    = !buf_full;
  assign accept      = in_valid && in_ready;
  assign comb_in     = buf_full ? {{(ACC_WIDTH-IN_WIDTH){buf_data[IN_WIDTH-1]}}, buf_data} : '0;
  assign integ_in    = (phase == 8'd0 && !rate_err) ? comb_out[STAGES-1] : '0;

  // A rate change flushes everything except the sticky underrun flag.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rate_q   <= '0;
      rate_err <= 1'b0;
      phase    <= '0;
      buf_data <= '0;
      buf_full <= 1'b0;
    end else if (rate_change) begin
      rate_q   <= rate;
      rate_err <= !rate_supported(rate);
      phase    <= '0;
      buf_data <= '0;
      buf_full <= 1'b0;
    end else begin
      if (ce_out && !rate_err) phase <= wrap ? 8'd0 : phase + 8'd1;
      if (accept && !rate_err) begin
        buf_data <= in_data;
        buf_full <= 1'b1;
      end else if (wrap) begin
        buf_full <= 1'b0;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset)                  underrun <= 1'b0;
    else if (wrap && !buf_full) underrun <= 1'b1;
    else if (underrun_clr)      underrun <= 1'b0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset || rate_change) begin
      for (int k = 0; k < STAGES; k++) begin
        comb_prev[k] <= '0;
        comb_out[k]  <= '0;
      end
    end else if (wrap) begin
      comb_prev[0] <= comb_in;
      comb_out[0]  <= comb_in - comb_prev[0];
      for (int k = 1; k < STAGES; k++) begin
        comb_prev[k] <= comb_out[k-1];
        comb_out[k]  <= comb_out[k-1] - comb_prev[k];
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset || rate_change) begin
      for (int k = 0; k < STAGES; k++) integ[k] <= '0;
    end else if (ce_out) begin
      integ[0] <= integ[0] + integ_in;
      for (int k = 1; k < STAGES; k++) integ[k] <= integ[k] + integ[k-1];
    end
  end

  // acc_sh[0] is the bit just below the output lsb and drives round-half-up.
  always_comb begin
    gain = 1;
    case (rate_q)
      8'd2:    gain = G_R2;
      8'd4:    gain = G_R4;
      8'd5:    gain = G_R5;
      8'd8:    gain = G_R8;
      8'd10:   gain = G_R10;
      8'd20:   gain = G_R20;
      8'd40:   gain = G_R40;
      default: gain = 1;
    endcase
    lsb_m1    = IN_WIDTH - OUT_WIDTH + gain - 1;
    acc_sh    = (OUT_WIDTH+1)'(integ[STAGES-1] >>> lsb_m1);
    trunc     = acc_sh[OUT_WIDTH:1];
    round_bit = acc_sh[0];
    rounded   = trunc + {{(OUT_WIDTH-1){1'b0}}, round_bit};
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ce_d      <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
`ifdef CIC_INTERP_SAT_EN
      sat_flag  <= 1'b0;
`endif
    end else begin
      ce_d      <= ce_out;
      out_valid <= ce_d;
      if (ce_d) begin
        if (rate_err) begin
          out_data <= '0;
`ifdef CIC_INTERP_SAT_EN
        end else if (round_bit && trunc == {1'b0, {(OUT_WIDTH-1){1'b1}}}) begin
          out_data <= {1'b0, {(OUT_WIDTH-1){1'b1}}};
          sat_flag <= 1'b1;
`endif
        end else begin
          out_data <= rounded;
        end
      end
    end
  end

endmodule

// File: tb/tb_cic_interp_var.sv
// Scoreboard bench for cic_interp_var: settled DC gain, pacing, underrun, rate change/error, async reset.
module tb_cic_interp_var;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic [7:0]        rate = 8'd8;
  logic              ce_out = 1'b0;
  logic signed [17:0] in_data = '0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic              in_req;
  logic signed [17:0] out_data;
  logic              out_valid;
  logic              underrun;
  logic              underrun_clr = 1'b0;
  logic              rate_err;

  int    checks = 0;
  int    errors = 0;
  int    ce_div = 1;
  int    ce_cnt = 0;
  int    in_req_cnt = 0;
  int    ov_cnt = 0;
  int    exp_q[$];
  string sb_name = "idle";
  logic signed [17:0] exp_v;

  cic_interp_var dut (
    .clock       (clock),
    .reset       (reset),
    .rate        (rate),
    .ce_out      (ce_out),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_req      (in_req),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .underrun    (underrun),
    .underrun_clr(underrun_clr),
    .rate_err    (rate_err)
  );

  initial forever #5 clock = ~clock;

  // High-rate enable: asserted once every ce_div clocks.
  initial forever begin
    @(negedge clock);
    ce_cnt = (ce_cnt + 1 >= ce_div) ? 0 : ce_cnt + 1;
    ce_out = (ce_cnt == 0);
  end

  initial forever begin
    @(negedge clock);
    #1;
    if (in_req) in_req_cnt++;
    if (out_valid) begin
      ov_cnt++;
      if (exp_q.size() > 0) begin
        exp_v = 18'(exp_q.pop_front());
        checks++;
        if (out_data !== exp_v) begin
          errors++;
          $display("[TB] FAIL %s out_data got %0d expected %0d", sb_name, out_data, exp_v);
        end
      end
    end
  end

  // Settled DC output for STAGES=3, equal in/out widths: round(val*R^2 / 2^ceil(log2 R^2)).
  function automatic int dc_expect(input int r, input int val);
    longint dc_gain;
    longint acc;
    int     g;
    dc_gain = longint'(r) * longint'(r);
    g = 0;
    while ((longint'(1) << g) < dc_gain) g++;
    acc = dc_gain * longint'(val);
    return int'((acc + (longint'(1) << (g - 1))) >>> g);
  endfunction

  task automatic wait_ce(input int n);
    int seen = 0;
    int cyc = 0;
    while (seen < n && cyc < n * ce_div + 20) begin
      @(negedge clock);
      #1;
      if (ce_out) seen++;
      cyc++;
    end
  endtask

  task automatic wait_req(input string name);
    int cyc = 0;
    do begin
      @(negedge clock);
      #1;
      cyc++;
    end while (!in_req && cyc < 200 * ce_div);
    if (!in_req) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s in_req timeout got 0 expected 1", name);
    end
  endtask

  task automatic drain();
    int cyc = 0;
    while (exp_q.size() > 0 && cyc < 40 * ce_div + 100) begin
      @(negedge clock);
      #2;
      cyc++;
    end
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s out_valid timeout got %0d pending expected 0", sb_name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic check_reset_values(input string name);
    checks++;
    if ({out_data, out_valid, in_req, in_ready, underrun, rate_err} !== {18'd0, 5'b00100}) begin
      errors++;
      $display("[TB] FAIL %s got %h expected %h", name,
               {out_data, out_valid, in_req, in_ready, underrun, rate_err}, {18'd0, 5'b00100});
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clock);
    #1;
    check_reset_values("reset_values");
    reset = 1'b0;
  endtask

  task automatic test_dc(input int r, input int val);
    sb_name = $sformatf("dc_r%0d_%0d", r, val);
    rate = 8'(r);
    in_data = 18'(val);
    in_valid = 1'b1;
    wait_ce(8 * r + 8);
    for (int i = 0; i < 12; i++) exp_q.push_back(dc_expect(r, val));
    drain();
    checks++;
    if (underrun !== 1'b0 || rate_err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL %s flags got underrun=%b rate_err=%b expected 0 0", sb_name, underrun, rate_err);
    end
  endtask

  task automatic test_req_pacing();
    test_dc(8, 1000);
    @(negedge clock);
    #2;
    in_req_cnt = 0;
    ov_cnt = 0;
    repeat (64) @(negedge clock);
    #2;
    checks++;
    if (in_req_cnt !== 8 || ov_cnt !== 64) begin
      errors++;
      $display("[TB] FAIL req_pacing got in_req=%0d out_valid=%0d expected 8 64", in_req_cnt, ov_cnt);
    end
  endtask

  task automatic test_underrun();
    ce_div = 3;
    test_dc(4, 1000);
    wait_req("underrun_arm");
    in_valid = 1'b0;
    wait_req("underrun_hit");
    in_valid = 1'b1;
    @(negedge clock);
    #1;
    checks++;
    if (underrun !== 1'b1) begin
      errors++;
      $display("[TB] FAIL underrun_set got %b expected 1", underrun);
    end
    wait_ce(12);
    checks++;
    if (underrun !== 1'b1) begin
      errors++;
      $display("[TB] FAIL underrun_sticky got %b expected 1", underrun);
    end
    underrun_clr = 1'b1;
    @(negedge clock);
    underrun_clr = 1'b0;
    #1;
    checks++;
    if (underrun !== 1'b0) begin
      errors++;
      $display("[TB] FAIL underrun_clear got %b expected 0", underrun);
    end
    sb_name = "underrun_recover";
    wait_ce(40);
    for (int i = 0; i < 8; i++) exp_q.push_back(1000);
    drain();
    ce_div = 1;
  endtask

  task automatic test_rate_change();
    int n = 0;
    int cyc = 0;
    test_dc(8, 1000);
    rate = 8'd20;
    @(posedge clock);
    do begin
      @(negedge clock);
      #1;
      if (ce_out) n++;
      cyc++;
    end while (!in_req && cyc < 100);
    checks++;
    if (!in_req || n !== 20) begin
      errors++;
      $display("[TB] FAIL rate_change_first_req got %0d ce_out (req=%b) expected 20", n, in_req);
    end
    sb_name = "rate_change_dc";
    wait_ce(8 * 20);
    for (int i = 0; i < 8; i++) exp_q.push_back(781);
    drain();
  endtask

  task automatic test_rate_err();
    rate = 8'd7;
    repeat (4) @(negedge clock);
    #2;
    checks++;
    if (rate_err !== 1'b1 || in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL rate_err_flag got rate_err=%b in_ready=%b expected 1 1", rate_err, in_ready);
    end
    in_req_cnt = 0;
    sb_name = "rate_err_zero";
    for (int i = 0; i < 10; i++) exp_q.push_back(0);
    drain();
    checks++;
    if (in_req_cnt !== 0) begin
      errors++;
      $display("[TB] FAIL rate_err_no_req got %0d expected 0", in_req_cnt);
    end
    test_dc(2, 1000);
  endtask

  task automatic test_async_reset();
    test_dc(2, 1000);
    @(negedge clock);
    #2;
    reset = 1'b1;
    #1;
    check_reset_values("async_reset");
    @(negedge clock);
    reset = 1'b0;
    test_dc(4, -2000);
  endtask

  initial begin
    test_reset();
    test_req_pacing();
    test_dc(10, 1000);
    test_dc(5, 1000);
    test_dc(10, -1000);
    test_underrun();
    test_rate_change();
    test_rate_err();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
